// File: rtl/fir_decim_sched.sv
// Decimating FIR filter: collects DECIM samples, then runs one tap per cycle through a 64-bit MAC.
// Define FIR_SATURATE_EN to clamp the output to the 32-bit signed range instead of wrapping.
module fir_decim_sched #(
  parameter int NUM_TAPS = 32,
  parameter int DECIM    = 8,
  parameter int BITS     = 10
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic signed [31:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic signed [31:0] out_data,
  input  logic               out_ready,
  input  logic               cfg_we,
  input  logic [4:0]         cfg_addr,
  input  logic signed [31:0] cfg_data,
  input  logic               flush,
  output logic               busy
);

  typedef enum logic [1:0] {LOAD = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

  localparam int IW = $clog2(NUM_TAPS + 1);
  localparam int CW = $clog2(DECIM + 1);
  localparam logic signed [63:0] RND = (64'sd1 <<< BITS) - 64'sd1;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic signed [63:0] acc_q, acc_d;
  logic signed [31:0] x_q [NUM_TAPS];
  logic signed [31:0] x_d [NUM_TAPS];
  logic signed [31:0] coef_q [NUM_TAPS];
  logic signed [31:0] coef_d [NUM_TAPS];
  logic signed [31:0] out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;

  logic signed [31:0] x_sel, c_sel;
  logic signed [63:0] prod, acc_adj;
  logic signed [31:0] quot32;
`ifdef FIR_SATURATE_EN
  logic signed [63:0] quot;
`endif

  // Tap operand select, product, and divide-by-2^BITS rounding toward zero.
  always_comb begin
    x_sel = 32'sd0;
    c_sel = 32'sd0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      x_sel = (int'(idx_q) == k) ? x_q[k] : x_sel;
      c_sel = (int'(idx_q) == k) ? coef_q[k] : c_sel;
    end
    prod = 64'(x_sel) * 64'(c_sel);
    // Biasing negative values before the arithmetic shift turns floor into truncation.
    if (acc_q[63]) begin
      acc_adj = acc_q + RND;
    end else begin
      acc_adj = acc_q;
    end
`ifdef FIR_SATURATE_EN
    quot = acc_adj >>> BITS;
    if (quot > 64'sd2147483647) begin
      quot32 = 32'sh7FFFFFFF;
    end else if (quot < -64'sd2147483648) begin
      quot32 = 32'sh80000000;
    end else begin
      quot32 = quot[31:0];
    end
`else
    quot32 = 32'(acc_adj >>> BITS);
`endif
  end

  // Next-state, datapath and coefficient-write logic.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    x_d        = x_q;
    coef_d     = coef_q;
    out_data_d = out_data_q;
    for (int k = 0; k < NUM_TAPS; k++) begin
      coef_d[k] = (cfg_we && (state_q == LOAD) && (int'(cfg_addr) == k)) ? cfg_data : coef_q[k];
    end
    if (flush) begin
      state_d = LOAD;
      count_d = '0;
      idx_d   = '0;
      acc_d   = 64'sd0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_d[k] = 32'sd0;
      end
    end else begin
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            for (int k = NUM_TAPS - 1; k > 0; k--) begin
              x_d[k] = x_q[k-1];
            end
            x_d[0] = in_data;
            if (count_q == CW'(DECIM - 1)) begin
              count_d = '0;
              acc_d   = 64'sd0;
              idx_d   = '0;
              state_d = MAC;
            end else begin
              count_d = count_q + CW'(1);
            end
          end else begin
            count_d = count_q;
          end
        end
        MAC: begin
          // One extra cycle after the last tap registers the result.
          if (idx_q == IW'(NUM_TAPS)) begin
            out_data_d = quot32;
            state_d    = OUT;
          end else begin
            acc_d = acc_q + prod;
            idx_d = idx_q + IW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            state_d = LOAD;
          end else begin
            state_d = OUT;
          end
        end
        default: state_d = LOAD;
      endcase
    end
    out_valid_d = (state_d == OUT);
    in_ready_d  = (state_d == LOAD);
    busy_d      = (state_d != LOAD);
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= LOAD;
      count_q     <= '0;
      idx_q       <= '0;
      acc_q       <= 64'sd0;
      out_data_q  <= 32'sd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        x_q[k]    <= 32'sd0;
        coef_q[k] <= 32'sd0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      x_q         <= x_d;
      coef_q      <= coef_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fir_decim_sched.sv
// Directed bench for fir_decim_sched: a reference model pushes expected outputs to a scoreboard queue.
module tb_fir_decim_sched;
  localparam int NT = 32;
  localparam int DM = 8;
  localparam int BT = 10;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data, cfg_data;
  logic        cfg_we, flush, busy;
  logic [4:0]  cfg_addr;

  always #5 clock = ~clock;

  fir_decim_sched #(.NUM_TAPS(NT), .DECIM(DM), .BITS(BT)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .flush(flush), .busy(busy)
  );

  int                 n_assert = 0;
  int                 n_fail = 0;
  logic [31:0]        sb_q[$];
  logic signed [31:0] coef_m [NT];
  logic signed [31:0] hist_m [NT];
  int                 cnt_m;
  logic               seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] model_out();
    longint acc = 0;
    longint q;
    for (int k = 0; k < NT; k++) acc += longint'(coef_m[k]) * longint'(hist_m[k]);
    q = acc / (longint'(1) << BT);
`ifdef FIR_SATURATE_EN
    if (q > 64'sd2147483647) return 32'h7FFFFFFF;
    if (q < -64'sd2147483648) return 32'h80000000;
`endif
    return q[31:0];
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NT; k++) hist_m[k] = 32'sd0;
    cnt_m = 0;
  endfunction

  task automatic write_coef(input int addr, input logic [31:0] data, input bit upd);
    @(negedge clock);
    cfg_we = 1'b1; cfg_addr = addr[4:0]; cfg_data = data;
    @(negedge clock);
    cfg_we = 1'b0;
    if (upd) coef_m[addr] = data;
  endtask

  task automatic send_sample(input logic [31:0] d);
    @(negedge clock);
    chk("in_ready before accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_data = d;
    @(negedge clock);
    in_valid = 1'b0;
    for (int k = NT - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = d;
    cnt_m++;
    if (cnt_m == DM) begin
      sb_q.push_back(model_out());
      cnt_m = 0;
    end
  endtask

  task automatic get_output(input string tag, input int exp_lat, input int hold);
    int          n = 0;
    logic [31:0] exp_v = 32'd0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk({tag, " valid"}, 64'(out_valid), 64'd1);
    if (exp_lat > 0) chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    n_assert++;
    assert (sb_q.size() > 0) else begin
      n_fail++;
      $error("FAIL %s scoreboard: observed empty queue, expected an entry", tag);
    end
    if (sb_q.size() > 0) exp_v = sb_q.pop_front();
    chk({tag, " data"}, 64'(out_data), 64'(exp_v));
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk({tag, " hold data"}, 64'(out_data), 64'(exp_v));
      chk({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, " hold valid"}, 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk({tag, " valid after handshake"}, 64'(out_valid), 64'd0);
    chk({tag, " in_ready after handshake"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = 5'd0; cfg_data = 32'd0; flush = 1'b0;
    for (int k = 0; k < NT; k++) coef_m[k] = 32'sd0;
    model_clear();
    repeat (3) @(negedge clock);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_data", 64'(out_data), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    reset_n = 1'b1;

    // Impulse through a ramp of coefficients: 1024 lands in x[7].
    for (int k = 0; k < NT; k++) write_coef(k, 32'(k * 1024), 1'b1);
    send_sample(32'd1024);
    for (int i = 0; i < 7; i++) send_sample(32'd0);
    chk("impulse mac in_ready", 64'(in_ready), 64'd0);
    chk("impulse mac busy", 64'(busy), 64'd1);
    chk("impulse model", 64'(sb_q[0]), 64'd7168);
    get_output("impulse", NT + 1, 0);

    // Truncation toward zero on a small negative accumulator.
    for (int k = 0; k < NT; k++) write_coef(k, (k == 0) ? 32'd1 : 32'd0, 1'b1);
    for (int i = 0; i < 7; i++) send_sample(32'd0);
    send_sample(-32'sd3);
    get_output("truncate", NT + 1, 0);

    // Backpressure: 20 cycles with out_ready low, then exactly one handshake.
    for (int i = 0; i < 7; i++) send_sample(32'd0);
    send_sample(32'd5000);
    get_output("backpressure", 0, 20);
    seen = 1'b0;
    repeat (10) begin @(negedge clock); seen |= out_valid; end
    chk("backpressure single handshake", 64'(seen), 64'd0);

    // Coefficient write while in MAC must be ignored (second pass exposes it).
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 7; i++) send_sample(32'd0);
      send_sample(32'd7000);
      cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 32'd12345;
      @(negedge clock);
      cfg_we = 1'b0;
      get_output("mac cfg write", 0, 0);
    end

    // Flush in MAC cycle 5 with a sample offered; history must restart from zero.
    for (int k = 0; k < NT; k++) write_coef(k, 32'((k + 1) * 1024), 1'b1);
    for (int i = 0; i < 8; i++) send_sample(32'(100 * (i + 1)));
    repeat (4) @(negedge clock);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'd999;
    @(negedge clock);
    flush = 1'b0; in_valid = 1'b0;
    void'(sb_q.pop_back());
    model_clear();
    chk("flush in_ready", 64'(in_ready), 64'd1);
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 7; i++) send_sample(32'(11 + i));
    seen = 1'b0;
    repeat (50) begin @(negedge clock); seen |= out_valid; end
    chk("flush no output before 8 fresh", 64'(seen), 64'd0);
    send_sample(32'd18);
    get_output("post flush", NT + 1, 0);

    // Large product: clamps with saturation, otherwise keeps the low 32 bits.
    for (int k = 0; k < NT; k++) write_coef(k, (k == 0) ? 32'h7FFFFFFF : 32'd0, 1'b1);
    for (int i = 0; i < 7; i++) send_sample(32'd0);
    send_sample(32'h7FFFFFFF);
    get_output("saturation", NT + 1, 0);

    // Reset in the middle of MAC: computation abandoned, coefficients cleared.
    for (int i = 0; i < 8; i++) send_sample(32'(3000 + i));
    repeat (3) @(negedge clock);
    chk("pre reset busy", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset in_ready", 64'(in_ready), 64'd1);
    chk("async reset busy", 64'(busy), 64'd0);
    chk("async reset out_valid", 64'(out_valid), 64'd0);
    chk("async reset out_data", 64'(out_data), 64'd0);
    void'(sb_q.pop_back());
    model_clear();
    for (int k = 0; k < NT; k++) coef_m[k] = 32'sd0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (60) begin @(negedge clock); seen |= out_valid; end
    chk("no output after mid-mac reset", 64'(seen), 64'd0);
    for (int i = 0; i < 8; i++) send_sample(32'(50 + i));
    get_output("after reset zero coefs", NT + 1, 0);

    chk("scoreboard drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
